// File: rtl/mu0_rst_pkg.sv
// mu0 reset generator shared definitions.
// State encoding and default timing parameters.
package mu0_rst_pkg;

  localparam int DB_MAX_DEF = 50000;
  localparam int HOLD_DEF   = 16;
  localparam int CNT_W_DEF  = 16;

  localparam logic [2:0] S_POR      = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_DEBOUNCE = 3'd2;
  localparam logic [2:0] S_ASSERT   = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;

  typedef enum logic [2:0] {
    ST_POR      = S_POR,
    ST_IDLE     = S_IDLE,
    ST_DEBOUNCE = S_DEBOUNCE,
    ST_ASSERT   = S_ASSERT,
    ST_WAIT_REL = S_WAIT_REL
  } state_t;

  function automatic logic is_rst(
    input state_t s
  );
    return (s == ST_POR) || (s == ST_ASSERT);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw button.
// Both flops clear on board reset.
module btn_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the async input through two flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_debounce.sv
// Pushbutton debouncer and reset request generator.
// Issues a HOLD-cycle reset pulse at power-on and per press.
module rst_debounce
  import mu0_rst_pkg::*;
#(
  parameter int DB_MAX = DB_MAX_DEF,
  parameter int HOLD   = HOLD_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic reset_req,
  output logic btn_db
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             db_n;
  logic             btn_s;

  btn_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn),
    .q       (btn_s)
  );

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_POR;
      cnt       <= '0;
      btn_db    <= 1'b0;
      reset_req <= 1'b1;
    end else begin
      state     <= nxt;
      cnt       <= cnt_n;
      btn_db    <= db_n;
      reset_req <= is_rst(nxt);
    end
  end

  // next-state, counter and debounced level decode
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    db_n  = btn_db;
    unique case (state)
      ST_POR: begin
        if (cnt == HOLD_LAST) begin
          nxt   = ST_IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      ST_IDLE: begin
        cnt_n = '0;
        if (btn_s) begin
          nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!btn_s) begin
          nxt   = ST_IDLE;
          cnt_n = '0;
        end else if (cnt == DB_LAST) begin
          nxt   = ST_ASSERT;
          cnt_n = '0;
          db_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      ST_ASSERT: begin
        if (cnt == HOLD_LAST) begin
          nxt   = ST_WAIT_REL;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      ST_WAIT_REL: begin
        if (btn_s) begin
          cnt_n = '0;
        end else if (cnt == DB_LAST) begin
          nxt   = ST_IDLE;
          cnt_n = '0;
          db_n  = 1'b0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        nxt   = ST_POR;
        cnt_n = '0;
        db_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_debounce.sv
// Self-checking bench for rst_debounce.
// Directed scenarios then random button traffic.
module tb_rst_debounce;

  localparam int DB = 4;
  localparam int HD = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic btn     = 1'b0;
  logic reset_req;
  logic btn_db;

  rst_debounce #(
    .DB_MAX (DB),
    .HOLD   (HD),
    .CNT_W  (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn       (btn),
    .reset_req (reset_req),
    .btn_db    (btn_db)
  );

  always #5 clk = ~clk;

  int   nasrt = 0;
  int   nfail = 0;
  int   rises = 0;
  logic prev_rr = 1'b1;

  // reference: sync delay line, pulse countdown,
  // run length of the level being qualified
  logic m_s1, m_s2;
  int   m_left;
  int   m_run;
  logic m_db;

  task automatic model_reset();
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_left = HD;
    m_run  = 0;
    m_db   = 1'b0;
  endtask

  task automatic model_edge();
    logic b;
    if (!reset_n) return;
    b    = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
    if (m_left > 0) begin
      m_left--;
      m_run = 0;
    end else if (!m_db) begin
      m_run = b ? m_run + 1 : 0;
      if (m_run == DB + 1) begin
        m_db   = 1'b1;
        m_left = HD;
        m_run  = 0;
      end
    end else begin
      m_run = b ? 0 : m_run + 1;
      if (m_run == DB) begin
        m_db  = 1'b0;
        m_run = 0;
      end
    end
  endtask

  task automatic chk(input string tag);
    logic e_rr;
    e_rr = (m_left > 0);
    nasrt++;
    assert (reset_req === e_rr) else begin
      nfail++;
      $error("FAIL %s reset_req obs=%b exp=%b t=%0t",
             tag, reset_req, e_rr, $time);
    end
    nasrt++;
    assert (btn_db === m_db) else begin
      nfail++;
      $error("FAIL %s btn_db obs=%b exp=%b t=%0t",
             tag, btn_db, m_db, $time);
    end
  endtask

  task automatic cyc(input logic b, input int n,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      btn = b;
      @(posedge clk);
      model_edge();
      #1;
      chk(tag);
      if (reset_req && !prev_rr) rises++;
      prev_rr = reset_req;
    end
  endtask

  task automatic rst_pulse(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_async"});
    @(posedge clk);
    #1;
    chk({tag, "_held"});
    reset_n = 1'b1;
    prev_rr = 1'b1;
  endtask

  task automatic cnt_chk(input string tag,
                         input int exp);
    nasrt++;
    assert (rises === exp) else begin
      nfail++;
      $error("FAIL %s pulses obs=%0d exp=%0d",
             tag, rises, exp);
    end
  endtask

  initial begin
    int first;
    int lvl;
    int len;
    model_reset();
    #2;
    rst_pulse("por");
    rises = 0;
    cyc(1'b0, 6, "por_idle");
    cnt_chk("por_pulses", 0);

    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1, "rise");
      if (reset_req && first == 0) first = i;
    end
    nasrt++;
    assert (first === 7) else begin
      nfail++;
      $error("FAIL latency obs=%0d exp=%0d",
             first, 7);
    end
    cyc(1'b0, 8, "rel");

    rises = 0;
    cyc(1'b1, 2, "bnc_a");
    cyc(1'b0, 1, "bnc_b");
    cyc(1'b1, 2, "bnc_c");
    cyc(1'b0, 8, "bnc_d");
    cnt_chk("bounce_pulses", 0);

    rises = 0;
    cyc(1'b1, 20, "hold");
    cyc(1'b0, 8, "hold_rel");
    cnt_chk("hold_pulses", 1);

    cyc(1'b1, 8, "pre_abort");
    rst_pulse("abort");
    cyc(1'b0, 8, "abort_por");

    rises = 0;
    cyc(1'b1, 10, "wr_hold");
    cyc(1'b0, 2, "wr_lo");
    cyc(1'b1, 1, "wr_bnc");
    cyc(1'b0, 8, "wr_rel");
    cnt_chk("rebounce_pulses", 1);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 30) == 0) begin
        rst_pulse("rnd_rst");
      end
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      cyc(lvl[0], len, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/rst_debounce.md
RST_DEBOUNCE -- requirements
Module: rst_debounce

Interface
REQ-001 SHALL have parameter DB_MAX, default 50000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter HOLD, default 16, meaning number of cycles reset_req is held high per reset event.
REQ-003 SHALL have parameter CNT_W, default 16, meaning counter width; DB_MAX and HOLD must each be at most 2^CNT_W-1.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset_n  input  1  asynchronous, active-low reset (power-on / board reset).
REQ-006 btn  input  1  raw pushbutton, asynchronous, bouncing, active-high.
REQ-007 reset_req  output  1  registered active-high reset request; drives the reset input of the downstream reset synchronizer.
REQ-008 btn_db  output  1  registered debounced button level.

Function
REQ-009 SHALL pass btn through a two-flop synchronizer; btn_s (second flop output) is the only internal use of btn.
REQ-010 SHALL implement FSM states POR, IDLE, DEBOUNCE, ASSERT, WAIT_REL.
REQ-011 POR: reset_req=1; cnt increments each cycle; when cnt==HOLD-1 -> IDLE with cnt=0.
REQ-012 IDLE: reset_req=0; btn_s==1 -> DEBOUNCE with cnt=0; otherwise stay.
REQ-013 DEBOUNCE: btn_s==0 -> IDLE with cnt=0 (bounce rejected); btn_s==1 and cnt==DB_MAX-1 -> ASSERT with cnt=0 and btn_db=1; otherwise cnt+1.
REQ-014 ASSERT: reset_req=1; cnt increments; when cnt==HOLD-1 -> WAIT_REL with cnt=0; btn_s is ignored during ASSERT.
REQ-015 WAIT_REL: reset_req=0; btn_s==1 -> cnt=0 and stay; btn_s==0 and cnt==DB_MAX-1 -> IDLE with btn_db=0; btn_s==0 otherwise -> cnt+1.
REQ-016 reset_req SHALL be a flop loaded from the next-state decode (1 iff next state is POR or ASSERT), so it is glitch-free and high for exactly HOLD cycles per event.
REQ-017 Latency: a clean btn rise sampled at edge k by the first sync flop SHALL assert reset_req at edge k+1+DB_MAX+1.
REQ-018 A held button SHALL produce exactly one reset_req pulse; a re-arm requires DB_MAX consecutive low cycles in WAIT_REL.
REQ-019 Counters SHALL never wrap; cnt is cleared on every state transition.
REQ-020 A btn pulse shorter than DB_MAX synchronized cycles SHALL produce no reset_req and leave btn_db=0.

Reset
REQ-021 reset_n low SHALL asynchronously force state=POR, reset_req=1, btn_db=0, cnt=0, both sync flops=0.
REQ-022 reset_n low mid-operation (any state) SHALL abort the current sequence; after release a full HOLD-cycle POR pulse SHALL be issued.
REQ-023 reset_n deassertion is assumed synchronous to clk by the board reset circuit; no internal synchronizer for reset_n.

Structure
REQ-024 State encoding localparams and default DB_MAX/HOLD/CNT_W values SHALL live in shared header mu0_rst_pkg.
REQ-025 The two-flop synchronizer SHALL be a sub-module named btn_sync (clk, reset_n, d, q).
REQ-026 All other logic (FSM, counter, output flops) SHALL reside in rst_debounce; no combinational output paths.

Verification (DB_MAX=4, HOLD=3)
REQ-027 Release reset_n, btn=0 -> reset_req=1 for exactly 3 cycles after release, then 0; btn_db=0 throughout.
REQ-028 btn 0->1 held -> reset_req rises at edge 1+4+1 after first sampling, stays high exactly 3 cycles, btn_db=1 from the same edge.
REQ-029 btn high 2 cycles, low 1, high 2, then low -> no reset_req pulse, btn_db stays 0.
REQ-030 btn held high 20 cycles -> single 3-cycle pulse; btn_db returns to 0 after 4 consecutive low synchronized cycles following release.
REQ-031 reset_n pulsed low during ASSERT (cycle 2 of 3) -> reset_req stays 1 asynchronously, then exactly 3 more cycles after release; state returns to IDLE.
REQ-032 Release btn, bounce 1 cycle high during WAIT_REL -> cnt restarts; IDLE reached only after 4 consecutive low cycles; no extra pulse.
